// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constant helpers for the pipelined adder.
//   seg_w(width, stages) : width of one pipeline segment
//   adder_op_t           : operation selected by the sub input
//   sat_max(w), sat_min(w) : two's-complement clamp limits for a w-bit result
//                            (returned in a wide vector; callers cast to width)
package adder_pkg;

    localparam int SAT_W = 256;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_t;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    // 2^(w-1) - 1
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    // -2^(w-1) as a w-bit pattern: only bit w-1 set
    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: one registered SEG-bit ripple-carry slice.
//   clk     : clock
//   en      : register enable (pipeline advance)
//   a, b    : SEG-bit segment operands
//   cin     : carry into bit 0 of the segment
//   s, cout : registered segment sum and carry out
// Data registers carry no reset; validity is tracked by the parent.
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           en,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0]   c;
    logic [SEG-1:0] s_comb;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s_comb[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s    <= s_comb;
            cout <= c[SEG];
        end
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep pipelined add/subtract with valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input beat handshake (in_ready = pipeline advance)
//   num1, num2          : WIDTH-bit operands
//   sub                 : 0 = num1 + num2 + carry_in, 1 = num1 - num2
//   carry_in            : carry into bit 0 (add only)
//   sat                 : clamp on signed overflow (only with ADDER_SAT_EN)
//   out_valid/out_ready : output beat handshake
//   sum, carry, overflow: result, carry out of MSB (1 = no borrow), signed overflow
// Build option: define ADDER_SAT_EN to add the sat port and output clamping.
// Stage k ripples bits [k*SEG +: SEG]; operands are skewed in, result segments
// de-skewed out so the whole sum leaves together after STAGES cycles.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             sub,
    input  logic             carry_in,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int SEG = seg_w(WIDTH, STAGES);
    localparam int MSB = WIDTH - 1;
    localparam int LST = STAGES - 1;

`ifdef ADDER_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

    // Positive overflow can only happen when both operands are non-negative,
    // so the sign of a selects the clamp direction.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] x,
        input logic                    ovf,
        input logic                    en,
        input logic                    a_neg
    );
        if (en && ovf) begin
            return a_neg ? SAT_LO : SAT_HI;
        end
        return x;
    endfunction
`endif

    adder_op_t        op;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             adv;

    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] b_p    [STAGES];
    logic [WIDTH-1:0] lo_p   [STAGES];
    logic [SEG-1:0]   s_p    [STAGES];
    logic             cout_p [STAGES];
    logic [WIDTH-1:0] view   [STAGES];
`ifdef ADDER_SAT_EN
    logic             sat_p  [STAGES];
`endif

    logic signed [WIDTH-1:0] raw_sum;
    logic signed [WIDTH-1:0] res_sum;
    logic                    a_msb;
    logic                    b_msb;
    logic                    ovf;

    assign op     = sub ? OP_SUB : OP_ADD;
    assign b_in   = (op == OP_SUB) ? ~num2 : num2;
    assign cin_in = (op == OP_SUB) ? 1'b1 : carry_in;

    // Whole pipe moves together; a stalled output freezes every stage.
    assign adv      = !vld_p[LST] || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // ---- stage boundaries: operand skew and result de-skew registers ----
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p[0]  <= num1;
            b_p[0]  <= b_in;
            lo_p[0] <= '0;
`ifdef ADDER_SAT_EN
            sat_p[0] <= sat;
`endif
            for (int k = 1; k < STAGES; k++) begin
                a_p[k]  <= a_p[k-1];
                b_p[k]  <= b_p[k-1];
                lo_p[k] <= view[k-1];
`ifdef ADDER_SAT_EN
                sat_p[k] <= sat_p[k-1];
`endif
            end
        end
    end

    // Result as seen after stage k: finished lower segments plus segment k.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            view[k] = lo_p[k];
            view[k][k*SEG +: SEG] = s_p[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic           seg_cin;

        if (k == 0) begin : g_first
            assign seg_a   = num1[SEG-1:0];
            assign seg_b   = b_in[SEG-1:0];
            assign seg_cin = cin_in;
        end else begin : g_rest
            assign seg_a   = a_p[k-1][k*SEG +: SEG];
            assign seg_b   = b_p[k-1][k*SEG +: SEG];
            assign seg_cin = cout_p[k-1];
        end

        adder_segment #(.SEG(SEG)) u_seg (
            .clk  (clk),
            .en   (adv),
            .a    (seg_a),
            .b    (seg_b),
            .cin  (seg_cin),
            .s    (s_p[k]),
            .cout (cout_p[k])
        );
    end

    // ---- last stage: overflow and optional clamp ----
    assign raw_sum = view[LST];
    assign a_msb   = a_p[LST][MSB];
    assign b_msb   = b_p[LST][MSB];
    assign ovf     = (a_msb == b_msb) && (raw_sum[MSB] != a_msb);

`ifdef ADDER_SAT_EN
    assign res_sum = saturate(raw_sum, ovf, sat_p[LST], a_msb);
`else
    assign res_sum = raw_sum;
`endif

    // Outputs read zero whenever no beat is presented, including after reset.
    assign out_valid = vld_p[LST];
    assign sum       = vld_p[LST] ? res_sum : '0;
    assign carry     = vld_p[LST] & cout_p[LST];
    assign overflow  = vld_p[LST] & ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             sub;
    logic             carry_in;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .sub       (sub),
        .carry_in  (carry_in),
`ifdef ADDER_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t q[$];
    exp_t none;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (observed=running expected=finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input logic ci, input logic st);
        exp_t         e;
        logic [WIDTH:0] wide;
        longint       sa, sb, r, smax, smin;
        logic         do_sat;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        if (s) begin
            wide    = {1'b0, a} - {1'b0, b};
            e.sum   = wide[WIDTH-1:0];
            e.carry = (a >= b);
            r       = sa - sb;
        end else begin
            wide    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
            e.sum   = wide[WIDTH-1:0];
            e.carry = wide[WIDTH];
            r       = sa + sb + longint'(ci);
        end
        e.ovf  = (r > smax) || (r < smin);
        do_sat = st;
`ifndef ADDER_SAT_EN
        do_sat = 1'b0;
`endif
        if (do_sat && e.ovf) begin
            e.sum = (r > smax) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
        end
        e.cyc = 0;
        return e;
    endfunction

    // One clock cycle: apply inputs at the falling edge, check at +1, queue accepted beats.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic ci, input logic st, input logic ordy,
                         input logic r, input bit use_exp, input exp_t ex,
                         output logic acc, output logic ir);
        exp_t e;
        rst = r; in_valid = iv; num1 = a; num2 = b; sub = s;
        carry_in = ci; sat = st; out_ready = ordy;
        #1;
        acc = 1'b0;
        ir  = in_ready;
        if (!r && q.size() == 0) begin
            chk("no_stale_out_valid", 64'(out_valid), 64'd0);
        end else if (!r && out_valid === 1'b1 && ordy) begin
            e = q.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("carry", 64'(carry), 64'(e.carry));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
            n_out++;
        end
        if (!r && iv && in_ready === 1'b1) begin
            e     = use_exp ? ex : model(a, b, s, ci, st);
            e.cyc = cyc;
            q.push_back(e);
            acc = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (r) q.delete();
    endtask

    task automatic idle(input int n);
        logic acc, ir;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, none, acc, ir);
    endtask

    task automatic send_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input logic ci, input logic st,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t ex;
        logic acc, ir;
        ex.sum = es; ex.carry = ec; ex.ovf = eo; ex.cyc = 0;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive(1'b1, a, b, s, ci, st, 1'b1, 1'b0, 1'b1, ex, acc, ir);
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) idle(1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = {1'b0, {(WIDTH-1){1'b1}}};
            3: v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic             acc, ir;
        logic [WIDTH-1:0] ra, rb;
        logic             rs, rc, rt;
        int               idx, out0;

        rst = 1'b1; in_valid = 1'b0; num1 = '0; num2 = '0; sub = 1'b0;
        carry_in = 1'b0; sat = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, none, acc, ir);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, none, acc, ir);

        // reset state
        rst = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_carry", 64'(carry), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // directed arithmetic
        lat_chk = 1'b1;
        send_exp(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        drain();
        send_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_exp(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_exp(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_exp(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef ADDER_SAT_EN
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        drain();

        // 10-beat stream with a three-cycle output stall
        lat_chk = 1'b0;
        idx  = 0;
        out0 = n_out;
        ra = rnd_operand(); rb = rnd_operand(); rs = 1'($urandom); rc = 1'($urandom); rt = 1'($urandom);
        for (int k = 0; k < 40; k++) begin
            if (idx >= 10 && q.size() == 0) break;
            drive(idx < 10, ra, rb, rs, rc, rt, !(k >= 6 && k <= 8), 1'b0, 1'b0, none, acc, ir);
            if (k < 14) chk("in_ready_stall", 64'(ir), 64'(!(k >= 6 && k <= 8)));
            if (acc) begin
                idx++;
                ra = rnd_operand(); rb = rnd_operand(); rs = 1'($urandom); rc = 1'($urandom); rt = 1'($urandom);
            end
        end
        chk("stream_accepted", 64'(idx), 64'd10);
        chk("stream_emitted", 64'(n_out - out0), 64'd10);

        // random traffic with random back-pressure
        ra = rnd_operand(); rb = rnd_operand(); rs = 1'($urandom); rc = 1'($urandom); rt = 1'($urandom);
        for (int k = 0; k < 120; k++) begin
            drive($urandom_range(0, 3) != 0, ra, rb, rs, rc, rt, $urandom_range(0, 3) != 0,
                  1'b0, 1'b0, none, acc, ir);
            if (acc) begin
                ra = rnd_operand(); rb = rnd_operand(); rs = 1'($urandom); rc = 1'($urandom); rt = 1'($urandom);
            end
        end
        drain();

        // reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, none, acc, ir);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, none, acc, ir);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_flush_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flush_in_ready", 64'(in_ready), 64'd1);
        lat_chk = 1'b1;
        send_exp(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        drain();
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
